// File: rtl/l1_fill_sequencer.sv
// L1 cache line fill sequencer: accepts one L2 fill response, obtains the LRU victim,
// writes back a dirty victim line, then writes the new tag and data into the arrays.
module l1_fill_sequencer #(
    parameter int NUM_SETS  = 64,
    parameter int NUM_WAYS  = 4,
    parameter int TAG_WIDTH = 20,
    parameter int LINE_BITS = 512,
    localparam int SET_IDX_W = $clog2(NUM_SETS),
    localparam int WAY_IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            resp_valid,
    output logic                            resp_ready,
    input  logic [SET_IDX_W-1:0]            resp_set,
    input  logic [TAG_WIDTH-1:0]            resp_tag,
    input  logic [LINE_BITS-1:0]            resp_data,
    output logic                            lru_fill_en,
    output logic [SET_IDX_W-1:0]            lru_fill_set,
    input  logic [WAY_IDX_W-1:0]            lru_fill_way,
    output logic                            tag_read_en,
    output logic [SET_IDX_W-1:0]            tag_read_set,
    input  logic [NUM_WAYS-1:0]             way_valid,
    input  logic [NUM_WAYS-1:0]             way_dirty,
    input  logic [NUM_WAYS*TAG_WIDTH-1:0]   way_tags,
    output logic                            data_read_en,
    output logic [SET_IDX_W-1:0]            data_read_set,
    output logic [WAY_IDX_W-1:0]            data_read_way,
    input  logic [LINE_BITS-1:0]            data_read_data,
    output logic                            wb_valid,
    input  logic                            wb_ready,
    output logic [TAG_WIDTH+SET_IDX_W-1:0]  wb_addr,
    output logic [LINE_BITS-1:0]            wb_data,
    output logic                            tag_write_en,
    output logic                            data_write_en,
    output logic [SET_IDX_W-1:0]            wr_set,
    output logic [WAY_IDX_W-1:0]            wr_way,
    output logic [TAG_WIDTH-1:0]            wr_tag,
    output logic [LINE_BITS-1:0]            wr_data,
    output logic                            fill_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_SELECT,
        S_WB_READ,
        S_WB_SEND,
        S_WRITE
    } state_t;

    state_t                         r_state;
    logic [SET_IDX_W-1:0]           r_set;
    logic [TAG_WIDTH-1:0]           r_tag;
    logic [LINE_BITS-1:0]           r_data;
    logic [WAY_IDX_W-1:0]           r_way;
    logic [TAG_WIDTH+SET_IDX_W-1:0] r_wb_addr;
    logic [LINE_BITS-1:0]           r_wb_data;
    logic                           r_resp_ready;
    logic                           r_lookup;
    logic                           r_wb_valid;
    logic                           r_write;

    logic [WAY_IDX_W-1:0]           w_way;
    logic                           w_victim_dirty;
    logic [TAG_WIDTH-1:0]           w_victim_tag;
    logic                           w_data_read_en;

    // The victim is always the LRU way; only its valid/dirty/tag slice matters.
    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_way          = (NUM_WAYS > 1) ? lru_fill_way : '0;
        w_victim_dirty = 1'b0;
        w_victim_tag   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (WAY_IDX_W'(i) == w_way) begin
                w_victim_dirty = way_valid[i] & way_dirty[i];
                w_victim_tag   = way_tags[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // The victim read must issue in SELECT itself so the line is back for WB_READ.
    assign w_data_read_en = (r_state == S_SELECT) && w_victim_dirty;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_set        <= '0;
            r_tag        <= '0;
            r_data       <= '0;
            r_way        <= '0;
            r_wb_addr    <= '0;
            r_wb_data    <= '0;
            r_resp_ready <= 1'b1;
            r_lookup     <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_write      <= 1'b0;
        end else begin
            r_lookup <= 1'b0;
            r_write  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (resp_valid) begin
                        r_set        <= resp_set;
                        r_tag        <= resp_tag;
                        r_data       <= resp_data;
                        r_resp_ready <= 1'b0;
                        r_lookup     <= 1'b1;
                        r_state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_state <= S_SELECT;
                end
                S_SELECT: begin
                    r_way <= w_way;
                    if (w_victim_dirty) begin
                        r_wb_addr <= {w_victim_tag, r_set};
                        r_state   <= S_WB_READ;
                    end else begin
                        r_write <= 1'b1;
                        r_state <= S_WRITE;
                    end
                end
                S_WB_READ: begin
                    r_wb_data  <= data_read_data;
                    r_wb_valid <= 1'b1;
                    r_state    <= S_WB_SEND;
                end
                S_WB_SEND: begin
                    if (wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_write    <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_resp_ready <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_resp_ready <= 1'b1;
                    r_wb_valid   <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    // Addresses are forced to zero whenever their enable is low.
    assign resp_ready    = r_resp_ready;
    assign lru_fill_en   = r_lookup;
    assign lru_fill_set  = r_lookup ? r_set : '0;
    assign tag_read_en   = r_lookup;
    assign tag_read_set  = r_lookup ? r_set : '0;
    assign data_read_en  = w_data_read_en;
    assign data_read_set = w_data_read_en ? r_set : '0;
    assign data_read_way = w_data_read_en ? w_way : '0;
    assign wb_valid      = r_wb_valid;
    assign wb_addr       = r_wb_valid ? r_wb_addr : '0;
    assign wb_data       = r_wb_data;
    assign tag_write_en  = r_write;
    assign data_write_en = r_write;
    assign fill_done     = r_write;
    assign wr_set        = r_write ? r_set : '0;
    assign wr_way        = r_write ? r_way : '0;
    assign wr_tag        = r_write ? r_tag : '0;
    assign wr_data       = r_data;

endmodule

// File: tb/tb_l1_fill_sequencer.sv
// Self-checking bench for l1_fill_sequencer: a table of fills replayed cycle by cycle,
// with a write/writeback scoreboard fed at drive time and drained when the DUT writes.
module tb_l1_fill_sequencer;

    localparam int NUM_SETS  = 64;
    localparam int NUM_WAYS  = 8;
    localparam int TAG_WIDTH = 20;
    localparam int LINE_BITS = 512;
    localparam int SET_IDX_W = 6;
    localparam int WAY_IDX_W = 3;
    localparam int NV        = 8;

    logic                           clk = 1'b0;
    logic                           reset;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [SET_IDX_W-1:0]           resp_set;
    logic [TAG_WIDTH-1:0]           resp_tag;
    logic [LINE_BITS-1:0]           resp_data;
    logic                           lru_fill_en;
    logic [SET_IDX_W-1:0]           lru_fill_set;
    logic [WAY_IDX_W-1:0]           lru_fill_way;
    logic                           tag_read_en;
    logic [SET_IDX_W-1:0]           tag_read_set;
    logic [NUM_WAYS-1:0]            way_valid;
    logic [NUM_WAYS-1:0]            way_dirty;
    logic [NUM_WAYS*TAG_WIDTH-1:0]  way_tags;
    logic                           data_read_en;
    logic [SET_IDX_W-1:0]           data_read_set;
    logic [WAY_IDX_W-1:0]           data_read_way;
    logic [LINE_BITS-1:0]           data_read_data;
    logic                           wb_valid;
    logic                           wb_ready;
    logic [TAG_WIDTH+SET_IDX_W-1:0] wb_addr;
    logic [LINE_BITS-1:0]           wb_data;
    logic                           tag_write_en;
    logic                           data_write_en;
    logic [SET_IDX_W-1:0]           wr_set;
    logic [WAY_IDX_W-1:0]           wr_way;
    logic [TAG_WIDTH-1:0]           wr_tag;
    logic [LINE_BITS-1:0]           wr_data;
    logic                           fill_done;

    l1_fill_sequencer #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS),
        .TAG_WIDTH(TAG_WIDTH),
        .LINE_BITS(LINE_BITS)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_set      (resp_set),
        .resp_tag      (resp_tag),
        .resp_data     (resp_data),
        .lru_fill_en   (lru_fill_en),
        .lru_fill_set  (lru_fill_set),
        .lru_fill_way  (lru_fill_way),
        .tag_read_en   (tag_read_en),
        .tag_read_set  (tag_read_set),
        .way_valid     (way_valid),
        .way_dirty     (way_dirty),
        .way_tags      (way_tags),
        .data_read_en  (data_read_en),
        .data_read_set (data_read_set),
        .data_read_way (data_read_way),
        .data_read_data(data_read_data),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .tag_write_en  (tag_write_en),
        .data_write_en (data_write_en),
        .wr_set        (wr_set),
        .wr_way        (wr_way),
        .wr_tag        (wr_tag),
        .wr_data       (wr_data),
        .fill_done     (fill_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [SET_IDX_W-1:0] set;
        logic [TAG_WIDTH-1:0] tag;
        logic [LINE_BITS-1:0] data;
        logic [WAY_IDX_W-1:0] way;
        bit                   valid;
        bit                   dirty;
        logic [TAG_WIDTH-1:0] vtag;
        logic [LINE_BITS-1:0] rd_data;
        int                   stall;
        bit                   chain;
        bit                   rst_in_send;
        bit                   exp_wb;
    } vec_t;

    typedef struct {
        logic [SET_IDX_W-1:0] set;
        logic [WAY_IDX_W-1:0] way;
        logic [TAG_WIDTH-1:0] tag;
        logic [LINE_BITS-1:0] data;
    } wr_exp_t;

    typedef struct {
        logic [TAG_WIDTH+SET_IDX_W-1:0] addr;
        logic [LINE_BITS-1:0]           data;
    } wb_exp_t;

    vec_t    vecs[NV];
    wr_exp_t q_wr[$];
    wb_exp_t q_wb[$];
    int      n_cmp  = 0;
    int      n_fail = 0;
    int      n_lru  = 0;

    task automatic check(input string name, input logic [LINE_BITS-1:0] act,
                         input logic [LINE_BITS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [SET_IDX_W-1:0] set, input logic [TAG_WIDTH-1:0] tag,
                                input logic [LINE_BITS-1:0] data, input logic [WAY_IDX_W-1:0] way,
                                input bit valid, input bit dirty, input logic [TAG_WIDTH-1:0] vtag,
                                input logic [LINE_BITS-1:0] rd_data, input int stall,
                                input bit chain, input bit rst_in_send, input bit exp_wb);
        vec_t v;
        v.set = set; v.tag = tag; v.data = data; v.way = way;
        v.valid = valid; v.dirty = dirty; v.vtag = vtag; v.rd_data = rd_data;
        v.stall = stall; v.chain = chain; v.rst_in_send = rst_in_send; v.exp_wb = exp_wb;
        return v;
    endfunction

    function automatic logic [LINE_BITS-1:0] rand_line();
        logic [LINE_BITS-1:0] l;
        for (int k = 0; k < LINE_BITS / 32; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    task automatic drive_resp(input vec_t v);
        resp_valid = 1'b1;
        resp_set   = v.set;
        resp_tag   = v.tag;
        resp_data  = v.data;
    endtask

    // Tag-array/LRU answers that are deliberately wrong outside the SELECT cycle.
    task automatic scramble_select(input vec_t v);
        lru_fill_way = v.way ^ 3'b101;
        way_valid    = v.valid ? ~(8'(1) << v.way) : (8'(1) << v.way);
        way_dirty    = v.dirty ? ~(8'(1) << v.way) : (8'(1) << v.way);
        way_tags     = ~way_tags;
    endtask

    task automatic drive_select(input vec_t v);
        logic [NUM_WAYS-1:0] m;
        m            = 8'(1) << v.way;
        lru_fill_way = v.way;
        way_valid    = v.valid ? m : ~m;
        way_dirty    = v.dirty ? m : ~m;
        for (int w = 0; w < NUM_WAYS; w++)
            way_tags[w*TAG_WIDTH +: TAG_WIDTH] = (w == int'(v.way)) ? v.vtag
                                                 : v.vtag ^ TAG_WIDTH'(32'h1111 * (w + 1));
    endtask

    task automatic do_reset_abort();
        #2;
        reset = 1'b1;
        #1;
        check("rst_wb_valid_async", wb_valid, 0);
        check("rst_resp_ready", resp_ready, 1);
        check("rst_tag_write_en", tag_write_en, 0);
        q_wr.delete();
        q_wb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post_rst_resp_ready", resp_ready, 1);
        check("post_rst_wb_valid", wb_valid, 0);
        check("post_rst_lru_fill_en", lru_fill_en, 0);
        step();
        check("post_rst_no_write", tag_write_en, 0);
    endtask

    // Entry: current cycle is IDLE with the response for v already on the bus.
    task automatic run_fill(input vec_t v, input bit chain, input vec_t nv);
        wr_exp_t we;
        wb_exp_t be;
        we.set = v.set; we.way = v.way; we.tag = v.tag; we.data = v.data;
        q_wr.push_back(we);
        if (v.exp_wb) begin
            be.addr = {v.vtag, v.set};
            be.data = v.rd_data;
            q_wb.push_back(be);
        end
        check("accept_resp_ready", resp_ready, 1);
        step();                                             // N+1: LOOKUP
        if (chain) drive_resp(nv);
        else begin
            resp_valid = 1'b0;
            resp_set   = ~v.set;
            resp_tag   = ~v.tag;
            resp_data  = ~v.data;
        end
        check("lookup_lru_fill_en", lru_fill_en, 1);
        check("lookup_lru_fill_set", lru_fill_set, v.set);
        check("lookup_tag_read_en", tag_read_en, 1);
        check("lookup_tag_read_set", tag_read_set, v.set);
        check("lookup_resp_ready", resp_ready, 0);
        step();                                             // N+2: SELECT
        drive_select(v);
        #1;
        check("select_lru_fill_en", lru_fill_en, 0);
        check("select_data_read_en", data_read_en, v.exp_wb);
        check("select_data_read_set", data_read_set, v.exp_wb ? v.set : '0);
        check("select_data_read_way", data_read_way, v.exp_wb ? v.way : '0);
        check("select_tag_write_en", tag_write_en, 0);
        step();
        scramble_select(v);
        if (v.exp_wb) begin                                 // N+3: WB_READ
            data_read_data = v.rd_data;
            check("wbread_wb_valid", wb_valid, 0);
            check("wbread_tag_write_en", tag_write_en, 0);
            step();                                         // N+4: WB_SEND
            data_read_data = ~v.rd_data;
            for (int s = 0; s <= v.stall; s++) begin
                wb_ready = (s == v.stall);
                check("wbsend_wb_valid", wb_valid, 1);
                check("wbsend_wb_addr", wb_addr, {v.vtag, v.set});
                check("wbsend_wb_data", wb_data, v.rd_data);
                check("wbsend_tag_write_en", tag_write_en, 0);
                check("wbsend_resp_ready", resp_ready, 0);
                if (v.rst_in_send && s == 1) begin
                    do_reset_abort();
                    return;
                end
                step();
            end
            wb_ready = 1'b0;
        end
        check("write_tag_write_en", tag_write_en, 1);       // WRITE
        check("write_data_write_en", data_write_en, 1);
        check("write_fill_done", fill_done, 1);
        check("write_wr_set", wr_set, v.set);
        check("write_wr_way", wr_way, v.way);
        check("write_wr_tag", wr_tag, v.tag);
        check("write_wr_data", wr_data, v.data);
        check("write_wb_valid", wb_valid, 0);
        check("write_resp_ready", resp_ready, 0);
        step();                                             // back in IDLE
        check("idle_tag_write_en", tag_write_en, 0);
        check("idle_fill_done", fill_done, 0);
        check("idle_wr_set", wr_set, 0);
        check("idle_resp_ready", resp_ready, 1);
    endtask

    // Scoreboard drain and LRU request counting, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (lru_fill_en) n_lru++;
            if (tag_write_en) begin
                if (q_wr.size() == 0) check("sb_unexpected_write", tag_write_en, 0);
                else begin
                    wr_exp_t e;
                    e = q_wr.pop_front();
                    check("sb_wr_set", wr_set, e.set);
                    check("sb_wr_way", wr_way, e.way);
                    check("sb_wr_tag", wr_tag, e.tag);
                    check("sb_wr_data", wr_data, e.data);
                end
            end
            if (wb_valid && wb_ready) begin
                if (q_wb.size() == 0) check("sb_unexpected_wb", wb_valid, 0);
                else begin
                    wb_exp_t e;
                    e = q_wb.pop_front();
                    check("sb_wb_addr", wb_addr, e.addr);
                    check("sb_wb_data", wb_data, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, n_cmp=%0d n_fail=%0d", n_cmp, n_fail);
        $fatal(1);
    end

    initial begin
        logic [LINE_BITS-1:0] pat_a, pat_b, pat_c;
        bit chained;
        pat_a = {16{32'hA5A5_0001}};
        pat_b = {16{32'h5A5A_BEEF}};
        pat_c = rand_line();

        reset = 1'b1; resp_valid = 1'b0; resp_set = '0; resp_tag = '0; resp_data = '0;
        lru_fill_way = '0; way_valid = '0; way_dirty = '0; way_tags = '0;
        data_read_data = '0; wb_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp_ready", resp_ready, 1);
        check("reset_lru_fill_en", lru_fill_en, 0);
        check("reset_tag_read_en", tag_read_en, 0);
        check("reset_data_read_en", data_read_en, 0);
        check("reset_wb_valid", wb_valid, 0);
        check("reset_wb_addr", wb_addr, 0);
        check("reset_wb_data", wb_data, 0);
        check("reset_tag_write_en", tag_write_en, 0);
        check("reset_fill_done", fill_done, 0);
        check("reset_wr_data", wr_data, 0);
        @(negedge clk);
        reset = 1'b0;

        //           set    tag        data         way  v  d  vtag       rd_data      stall ch rst wb
        vecs[0] = mk(6'd5,  20'h00123, pat_a,       3'd2, 1, 0, 20'h0AAAA, '0,          0,   0, 0,  0);
        vecs[1] = mk(6'd9,  20'h00456, pat_c,       3'd1, 1, 1, 20'h00ABC, pat_b,       3,   0, 0,  1);
        vecs[2] = mk(6'd12, 20'h00789, rand_line(), 3'd3, 0, 1, 20'h0BBBB, rand_line(), 0,   0, 0,  0);
        vecs[3] = mk(6'd63, 20'h0F0F0, rand_line(), 3'd7, 1, 1, 20'hFEDCB, rand_line(), 0,   0, 0,  1);
        vecs[4] = mk(6'd20, 20'h11111, rand_line(), 3'd0, 1, 0, 20'h0CCCC, '0,          0,   1, 0,  0);
        vecs[5] = mk(6'd21, 20'h22222, rand_line(), 3'd4, 1, 1, 20'h33333, rand_line(), 1,   0, 0,  1);
        vecs[6] = mk(6'd30, 20'h44444, rand_line(), 3'd6, 1, 1, 20'h55555, rand_line(), 4,   0, 1,  1);
        vecs[7] = mk(6'd0,  20'hFFFFF, rand_line(), 3'd5, 0, 0, 20'h0DDDD, '0,          0,   0, 0,  0);

        chained = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (!chained) begin
                step();
                drive_resp(vecs[i]);
            end
            run_fill(vecs[i], vecs[i].chain, vecs[(i + 1) % NV]);
            chained = vecs[i].chain;
            check("lru_fill_en_once_per_fill", n_lru, i + 1);
        end

        repeat (3) step();
        check("sb_wr_drained", q_wr.size(), 0);
        check("sb_wb_drained", q_wb.size(), 0);
        check("lru_fill_en_total", n_lru, NV);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
